// File: rtl/breath_led_multi.sv
// Multi-channel breathing-LED driver: shared prescaler/PWM frame timebase, per-channel
// OFF/ON/BREATH/BLINK modes, and a single-entry valid/ready config shadow applied at frame end.
module breath_led_multi #(
    parameter int unsigned  CH_NUM       = 4,
    parameter int unsigned  PWM_BITS     = 8,
    parameter int unsigned  PRESCALE     = 100,
    parameter int unsigned  BLINK_FRAMES = 64,
    parameter bit           ACTIVE_LOW   = 1'b0,
    localparam int unsigned CH_W         = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                sclk,
    input  logic                s_rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_step,
    output logic [CH_NUM-1:0]   led,
    output logic                frame_pulse
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PWM_BITS-1:0] DMAX    = {PWM_BITS{1'b1}};
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [BF_W-1:0]     BF_LAST = BF_W'(BLINK_FRAMES - 1);

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_ON     = 2'd1;
    localparam logic [1:0] MODE_BREATH = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    logic [PS_W-1:0]     prescaler_q, prescaler_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BF_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic                pending_q, pending_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic [CH_W-1:0]     sh_ch_q, sh_ch_d;
    logic [1:0]          sh_mode_q, sh_mode_d;
    logic [PWM_BITS-1:0] sh_step_q, sh_step_d;
    logic [CH_NUM-1:0]   led_q, led_d;

    logic [1:0]          mode_q [CH_NUM];
    logic [1:0]          mode_d [CH_NUM];
    logic [PWM_BITS-1:0] duty_q [CH_NUM];
    logic [PWM_BITS-1:0] duty_d [CH_NUM];
    logic [PWM_BITS-1:0] step_q [CH_NUM];
    logic [PWM_BITS-1:0] step_d [CH_NUM];
    logic                dir_q  [CH_NUM];  // 0 = ramping up, 1 = ramping down
    logic                dir_d  [CH_NUM];

    logic tick, frame_end, xfer, apply;
    logic [CH_NUM-1:0]   raw;
    logic [PWM_BITS:0]   sum;

    assign tick        = (prescaler_q == PS_LAST);
    assign frame_end   = tick && (pwm_cnt_q == DMAX);
    assign xfer        = cfg_valid && cfg_ready_q;
    // A transfer can only happen while nothing is pending, so a same-cycle frame_end never applies it.
    assign apply       = frame_end && pending_q;
    assign frame_pulse = frame_end;
    assign cfg_ready   = cfg_ready_q;
    assign led         = led_q;

    always_comb begin
        prescaler_d   = tick ? '0 : prescaler_q + 1'b1;
        pwm_cnt_d     = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_end) begin
            if (blink_cnt_q == BF_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        pending_d = pending_q;
        sh_ch_d   = sh_ch_q;
        sh_mode_d = sh_mode_q;
        sh_step_d = sh_step_q;
        if (apply) pending_d = 1'b0;
        if (xfer) begin
            pending_d = 1'b1;
            sh_ch_d   = cfg_ch;
            sh_mode_d = cfg_mode;
            sh_step_d = cfg_step;
        end
        cfg_ready_d = ~pending_d;

        sum = '0;
        raw = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            mode_d[i] = mode_q[i];
            duty_d[i] = duty_q[i];
            step_d[i] = step_q[i];
            dir_d[i]  = dir_q[i];
            sum       = {1'b0, duty_q[i]} + {1'b0, step_q[i]};
            if (frame_end) begin
                if (apply && (32'(sh_ch_q) == i)) begin
                    mode_d[i] = sh_mode_q;
                    duty_d[i] = '0;
                    dir_d[i]  = 1'b0;
                    if (sh_mode_q == MODE_BREATH) begin
                        step_d[i] = (sh_step_q == '0) ? PWM_BITS'(1) : sh_step_q;
                    end
                end else if (mode_q[i] == MODE_BREATH) begin
                    if (!dir_q[i]) begin
                        if (sum >= {1'b0, DMAX}) begin
                            duty_d[i] = DMAX;
                            dir_d[i]  = 1'b1;
                        end else begin
                            duty_d[i] = sum[PWM_BITS-1:0];
                        end
                    end else if (duty_q[i] <= step_q[i]) begin
                        duty_d[i] = '0;
                        dir_d[i]  = 1'b0;
                    end else begin
                        duty_d[i] = duty_q[i] - step_q[i];
                    end
                end
            end
            unique case (mode_q[i])
                MODE_OFF:    raw[i] = 1'b0;
                MODE_ON:     raw[i] = 1'b1;
                MODE_BREATH: raw[i] = (pwm_cnt_q < duty_q[i]);
                MODE_BLINK:  raw[i] = blink_phase_q;
                default:     raw[i] = 1'b0;
            endcase
        end
        led_d = raw ^ {CH_NUM{ACTIVE_LOW}};
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            prescaler_q   <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pending_q     <= 1'b0;
            cfg_ready_q   <= 1'b0;
            sh_ch_q       <= '0;
            sh_mode_q     <= MODE_OFF;
            sh_step_q     <= '0;
            led_q         <= {CH_NUM{ACTIVE_LOW}};
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                mode_q[i] <= MODE_OFF;
                duty_q[i] <= '0;
                step_q[i] <= PWM_BITS'(1);
                dir_q[i]  <= 1'b0;
            end
        end else begin
            prescaler_q   <= prescaler_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pending_q     <= pending_d;
            cfg_ready_q   <= cfg_ready_d;
            sh_ch_q       <= sh_ch_d;
            sh_mode_q     <= sh_mode_d;
            sh_step_q     <= sh_step_d;
            led_q         <= led_d;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                mode_q[i] <= mode_d[i];
                duty_q[i] <= duty_d[i];
                step_q[i] <= step_d[i];
                dir_q[i]  <= dir_d[i];
            end
        end
    end

endmodule

// File: tb/tb_breath_led_multi.sv
// Bench for breath_led_multi: main 2-channel instance, an ACTIVE_LOW twin compared cycle by cycle,
// and a 3-channel instance that can address an out-of-range channel.
module tb_breath_led_multi;

    localparam int NF = 18;  // frames measured per table record

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_step;

    logic       rdy, fp;
    logic [1:0] led;
    logic       rdy_al, fp_al;
    logic [1:0] led_al;
    logic       rdy3, fp3;
    logic [2:0] led3;

    int n_chk  = 0;
    int n_fail = 0;
    bit al_en  = 1'b0;

    always #5 clk = ~clk;

    breath_led_multi #(.CH_NUM(2), .PWM_BITS(4), .PRESCALE(2), .BLINK_FRAMES(2),
                       .ACTIVE_LOW(1'b0)) u_dut (
        .sclk(clk), .s_rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy), .cfg_ch(cfg_ch[0]),
        .cfg_mode(cfg_mode), .cfg_step(cfg_step), .led(led), .frame_pulse(fp)
    );

    breath_led_multi #(.CH_NUM(2), .PWM_BITS(4), .PRESCALE(2), .BLINK_FRAMES(2),
                       .ACTIVE_LOW(1'b1)) u_dut_al (
        .sclk(clk), .s_rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy_al), .cfg_ch(cfg_ch[0]),
        .cfg_mode(cfg_mode), .cfg_step(cfg_step), .led(led_al), .frame_pulse(fp_al)
    );

    breath_led_multi #(.CH_NUM(3), .PWM_BITS(4), .PRESCALE(2), .BLINK_FRAMES(2),
                       .ACTIVE_LOW(1'b0)) u_dut3 (
        .sclk(clk), .s_rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy3), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_step(cfg_step), .led(led3), .frame_pulse(fp3)
    );

    typedef struct packed {
        logic [1:0] ch;
        logic [1:0] mode;
        logic [3:0] step;
    } vec_t;

    vec_t vecs [4];
    int   lit_exp [4][NF];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ACTIVE_LOW twin must always be the exact bitwise inverse with identical handshake/timebase.
    always @(negedge clk) begin
        if (al_en) begin
            logic [1:0] inv;
            inv = ~led;
            check("al_led_inverse", {30'b0, led_al}, {30'b0, inv});
            check("al_ready", {31'b0, rdy_al}, {31'b0, rdy});
            check("al_frame_pulse", {31'b0, fp_al}, {31'b0, fp});
        end
    end

    // Write one config; returns at the sample right after the apply cycle.
    task automatic do_write(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] stp);
        int t;
        t = 0;
        while (rdy !== 1'b1 && t < 100) begin
            cyc();
            t++;
        end
        check("ready_before_write", {31'b0, rdy}, 32'd1);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_step  = stp;
        cyc();
        cfg_valid = 1'b0;
        check("ready_low_after_xfer", {31'b0, rdy}, 32'd0);
        t = 0;
        while (fp !== 1'b1 && t < 40) begin
            cyc();
            t++;
        end
        check("apply_frame_pulse_seen", {31'b0, fp}, 32'd1);
        check("ready_low_at_apply", {31'b0, rdy}, 32'd0);
        cyc();
        check("ready_high_after_apply", {31'b0, rdy}, 32'd1);
    endtask

    // Lit cycles of led[ch] in the next frame window (starts two samples after a frame_pulse).
    task automatic measure_frame(input int ch, output int lit);
        lit = 0;
        for (int k = 0; k < 32; k++) begin
            cyc();
            if (led[ch] === 1'b1) lit++;
        end
    endtask

    initial begin
        int lit;
        int changes, last_t;
        logic prev, cur, p1, p2;
        logic [2:0] any3;
        logic [1:0] any_led;

        vecs[0] = '{ch: 2'd0, mode: 2'd1, step: 4'd0};
        vecs[1] = '{ch: 2'd1, mode: 2'd2, step: 4'd5};
        vecs[2] = '{ch: 2'd1, mode: 2'd2, step: 4'd0};
        vecs[3] = '{ch: 2'd1, mode: 2'd0, step: 4'd7};
        lit_exp[0] = '{32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32};
        lit_exp[1] = '{0, 10, 20, 30, 20, 10, 0, 10, 20, 30, 20, 10, 0, 10, 20, 30, 20, 10};
        lit_exp[2] = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 22, 24, 26, 28, 30, 28, 26};
        lit_exp[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_mode  = 2'd0;
        cfg_step  = 4'd0;

        // Reset for 3 cycles, then the timebase from release.
        for (int i = 0; i < 3; i++) begin
            cyc();
            al_en = 1'b1;
            check("reset_led", {30'b0, led}, 32'd0);
            check("reset_ready", {31'b0, rdy}, 32'd0);
            check("reset_frame_pulse", {31'b0, fp}, 32'd0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            cyc();
            if (i == 1) check("ready_after_release", {31'b0, rdy}, 32'd1);
            check("first_frame_pulse", {31'b0, fp}, {31'b0, (i == 31)});
        end
        for (int i = 1; i <= 32; i++) begin
            cyc();
            check("second_frame_pulse", {31'b0, fp}, {31'b0, (i == 32)});
        end

        // Table-driven: ON, BREATH step 5, BREATH step 0, OFF.
        for (int v = 0; v < 4; v++) begin
            repeat (7) cyc();  // land mid-frame
            do_write(vecs[v].ch, vecs[v].mode, vecs[v].step);
            for (int f = 0; f < NF; f++) begin
                measure_frame(int'(vecs[v].ch), lit);
                check($sformatf("vec%0d_frame%0d_lit", v, f), lit, lit_exp[v][f]);
            end
        end

        // BLINK on ch0: edges 64 cycles apart, each two samples after a frame_pulse.
        do_write(2'd0, 2'd3, 4'd0);
        cyc();
        prev    = led[0];
        p1      = fp;
        p2      = 1'b0;
        changes = 0;
        last_t  = -1;
        for (int t = 0; t < 256; t++) begin
            cyc();
            cur = led[0];
            if (cur !== prev) begin
                changes++;
                check("blink_edge_after_pulse", {31'b0, p2}, 32'd1);
                if (last_t >= 0) check("blink_half_period", t - last_t, 64);
                last_t = t;
            end
            p2   = p1;
            p1   = fp;
            prev = cur;
        end
        check("blink_edge_count", changes, 4);

        // Out-of-range channel on the 3-channel instance: handshake completes, nothing lights.
        do_write(2'd0, 2'd0, 4'd0);
        do_write(2'd1, 2'd0, 4'd0);
        do_write(2'd3, 2'd1, 4'd0);
        any3 = 3'b000;
        for (int t = 0; t < 40; t++) begin
            cyc();
            any3 = any3 | led3;
        end
        check("out_of_range_no_change", {29'b0, any3}, 32'd0);

        // Reset mid-BREATH, then the ramp restarts from zero.
        do_write(2'd1, 2'd2, 4'd5);
        for (int f = 0; f < 3; f++) begin
            measure_frame(1, lit);
            check("pre_reset_breath_lit", lit, 10 * f);
        end
        repeat (9) cyc();
        rst = 1'b1;
        cyc();
        check("midrun_reset_led", {30'b0, led}, 32'd0);
        check("midrun_reset_led3", {29'b0, led3}, 32'd0);
        check("midrun_reset_ready", {31'b0, rdy}, 32'd0);
        check("midrun_reset_frame_pulse", {31'b0, fp}, 32'd0);
        rst = 1'b0;
        cyc();
        check("ready_after_midrun_release", {31'b0, rdy}, 32'd1);
        any_led = 2'b00;
        for (int t = 0; t < 40; t++) begin
            cyc();
            any_led = any_led | led;
        end
        check("led_off_after_reset", {30'b0, any_led}, 32'd0);
        do_write(2'd1, 2'd2, 4'd5);
        for (int f = 0; f < 4; f++) begin
            measure_frame(1, lit);
            check("post_reset_breath_lit", lit, 10 * f);
        end

        al_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
